// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared state encoding and widths for the wait-state data memory.
package data_mem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;
  localparam int ADDR_LSB = 3;
  localparam int CNT_W = 4;
endpackage

// File: rtl/dm_wait_counter.sv
// dm_wait_counter: loadable down-counter that flags the last wait cycle.
module dm_wait_counter
  import data_mem_pkg::*;
(
  input  logic             Clk,
  input  logic             ResetL,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             is_one
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : dec ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge Clk or negedge ResetL)
    if (!ResetL) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign is_one = cnt_q == CNT_W'(1);
endmodule

// File: rtl/data_memory_wait.sv
// data_memory_wait: doubleword data memory with programmable latency and Busy/Done handshake.
module data_memory_wait
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        ResetL,
  input  logic [63:0] Address,
  input  logic [63:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [63:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);
  localparam bit NO_WAIT = WAIT_STATES == 0;
  state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, idx_eff;
  logic [63:0] wdata_q, wdata_d, wd_eff, rdata_q, rdata_d;
  logic rd_q, rd_d, wr_q, wr_d, rd_eff, wr_eff;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic idle, req, bad, bad_eff, enter_done, acc, mem_we, cnt_load, cnt_dec, cnt_is_one;
  logic [63:0] mem [DEPTH_WORDS];
  dm_wait_counter u_cnt (
    .Clk(Clk), .ResetL(ResetL), .load(cnt_load), .dec(cnt_dec),
    .load_val(WS), .is_one(cnt_is_one)
  );
  // In IDLE the access may complete on the accepting edge, so use live inputs there.
  always_comb begin
    idle = state_q == IDLE;
    req = MemRead | MemWrite;
    bad = (MemRead & MemWrite) | (|Address[ADDR_LSB-1:0]) | (|Address[63:AW+ADDR_LSB]);
    bad_eff = idle & bad;
    cnt_load = idle & req;
    cnt_dec = state_q == WAIT;
    enter_done = idle ? req & (bad | NO_WAIT) : cnt_dec & cnt_is_one;
    idx_eff = idle ? Address[AW+ADDR_LSB-1:ADDR_LSB] : idx_q;
    wd_eff = idle ? WriteData : wdata_q;
    rd_eff = idle ? MemRead : rd_q;
    wr_eff = idle ? MemWrite : wr_q;
    acc = enter_done & ~bad_eff;
    mem_we = acc & wr_eff & ResetL;
    state_d = enter_done ? DONE : cnt_load ? WAIT : state_q == DONE ? IDLE : state_q;
    idx_d = cnt_load ? Address[AW+ADDR_LSB-1:ADDR_LSB] : idx_q;
    wdata_d = cnt_load ? WriteData : wdata_q;
    rd_d = cnt_load ? MemRead : rd_q;
    wr_d = cnt_load ? MemWrite : wr_q;
    rdata_d = acc & rd_eff ? mem[idx_eff] : rdata_q;
    busy_d = state_d != IDLE;
    done_d = enter_done;
    err_d = enter_done & bad_eff;
  end
  always_ff @(posedge Clk or negedge ResetL)
    if (!ResetL) begin
      state_q <= IDLE;
      idx_q <= '0;
      wdata_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      rdata_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      rdata_q <= rdata_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  always_ff @(posedge Clk)
    if (mem_we) mem[idx_eff] <= wd_eff;
  assign ReadData = rdata_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Err = err_q;
endmodule

// File: tb/tb_data_memory_wait.sv
// tb_data_memory_wait: directed scoreboard bench for two latency configurations.
module tb_data_memory_wait;
  typedef struct {
    logic        err;
    logic [63:0] data;
  } exp_t;
  logic Clk = 1'b0, ResetL = 1'b0;
  logic [63:0] addr2 = '0, wd2 = '0, addr0 = '0, wd0 = '0;
  logic rd2 = 1'b0, wr2 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
  logic [63:0] rdata2, rdata0;
  logic busy2, done2, err2, busy0, done0, err0;
  exp_t q2[$], q0[$];
  logic [63:0] m2 [256], m0 [256];
  logic [63:0] lr2 = '0, lr0 = '0;
  int total = 0, bad = 0;
  int lat;
  always #5 Clk = ~Clk;
  data_memory_wait #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u2 (
    .Clk(Clk), .ResetL(ResetL), .Address(addr2), .WriteData(wd2), .MemRead(rd2),
    .MemWrite(wr2), .ReadData(rdata2), .Busy(busy2), .Done(done2), .Err(err2)
  );
  data_memory_wait #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u0 (
    .Clk(Clk), .ResetL(ResetL), .Address(addr0), .WriteData(wd0), .MemRead(rd0),
    .MemWrite(wr0), .ReadData(rdata0), .Busy(busy0), .Done(done0), .Err(err0)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Expected results are queued at acceptance and popped on each Done pulse.
  always @(negedge Clk) begin
    if (done2) begin
      if (q2.size() == 0) chk("done2_unexpected", 64'(done2), 64'd0);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("rdata2", rdata2, e.data);
        chk("err2", 64'(err2), 64'(e.err));
      end
    end else chk("err2_idle", 64'(err2), 64'd0);
    if (done0) begin
      if (q0.size() == 0) chk("done0_unexpected", 64'(done0), 64'd0);
      else begin
        exp_t e;
        e = q0.pop_front();
        chk("rdata0", rdata0, e.data);
        chk("err0", 64'(err0), 64'(e.err));
      end
    end else chk("err0_idle", 64'(err0), 64'd0);
  end
  task automatic drive(input bit sel, input bit rd, input bit wr, input logic [63:0] a,
                       input logic [63:0] d, input bit sb, output int l);
    bit e;
    exp_t x;
    e = (rd && wr) || (a[2:0] != 3'd0) || (a >= 64'h800);
    l = (e || !sel) ? 1 : 3;
    @(negedge Clk);
    if (sel) begin rd2 = rd; wr2 = wr; addr2 = a; wd2 = d; end
    else begin rd0 = rd; wr0 = wr; addr0 = a; wd0 = d; end
    if (sb) begin
      if (!e && wr) begin if (sel) m2[a[10:3]] = d; else m0[a[10:3]] = d; end
      if (!e && rd) begin if (sel) lr2 = m2[a[10:3]]; else lr0 = m0[a[10:3]]; end
      x.err = e;
      x.data = sel ? lr2 : lr0;
      if (sel) q2.push_back(x); else q0.push_back(x);
    end
    @(posedge Clk);
    #1;
    if (sel) begin rd2 = 1'b0; wr2 = 1'b0; end
    else begin rd0 = 1'b0; wr0 = 1'b0; end
  endtask
  task automatic wait_done(input bit sel, input int l, input int k0);
    for (int k = k0; k <= l + 1; k++) begin
      @(negedge Clk);
      chk(sel ? "busy2" : "busy0", 64'(sel ? busy2 : busy0), 64'(k <= l));
      chk(sel ? "done2" : "done0", 64'(sel ? done2 : done0), 64'(k == l));
    end
  endtask
  task automatic access(input bit sel, input bit rd, input bit wr, input logic [63:0] a,
                        input logic [63:0] d);
    int l;
    drive(sel, rd, wr, a, d, 1'b1, l);
    wait_done(sel, l, 1);
  endtask
  initial begin
    #7;
    chk("rst_rdata2", rdata2, 64'd0);
    chk("rst_busy2", 64'(busy2), 64'd0);
    chk("rst_done2", 64'(done2), 64'd0);
    chk("rst_err2", 64'(err2), 64'd0);
    chk("rst_busy0", 64'(busy0), 64'd0);
    #13 ResetL = 1'b1;
    access(1, 0, 1, 64'h18, 64'h0123456789ABCDEF);
    access(1, 1, 0, 64'h18, 64'h0);
    access(1, 0, 1, 64'h10, 64'h1111);
    drive(1, 0, 1, 64'h10, 64'hDEAD, 1'b0, lat);
    @(negedge Clk);
    chk("abort_busy_pre", 64'(busy2), 64'd1);
    #2 ResetL = 1'b0;
    #1;
    chk("abort_rdata", rdata2, 64'd0);
    chk("abort_busy", 64'(busy2), 64'd0);
    chk("abort_done", 64'(done2), 64'd0);
    chk("abort_err", 64'(err2), 64'd0);
    lr2 = '0;
    lr0 = '0;
    @(negedge Clk);
    ResetL = 1'b1;
    access(1, 1, 0, 64'h10, 64'h0);
    access(1, 0, 1, 64'h0, 64'hA0);
    access(1, 0, 1, 64'h8, 64'h88);
    access(1, 1, 0, 64'h1C, 64'h0);
    access(1, 0, 1, 64'h800, 64'hBAD);
    access(1, 1, 1, 64'h8, 64'hFF);
    access(1, 1, 0, 64'h0, 64'h0);
    access(1, 1, 0, 64'h8, 64'h0);
    drive(1, 0, 1, 64'h20, 64'h2020, 1'b1, lat);
    @(negedge Clk);
    chk("ign_busy1", 64'(busy2), 64'd1);
    rd2 = 1'b1;
    addr2 = 64'h18;
    @(negedge Clk);
    chk("ign_busy2", 64'(busy2), 64'd1);
    chk("ign_done2", 64'(done2), 64'd0);
    rd2 = 1'b0;
    wait_done(1, lat, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk("ign_no_second", 64'(done2), 64'd0);
    end
    access(1, 1, 0, 64'h20, 64'h0);
    @(negedge Clk);
    wr2 = 1'b1;
    addr2 = 64'h28;
    wd2 = 64'hB2B;
    m2[5] = 64'hB2B;
    for (int k = 0; k < 3; k++) begin
      exp_t x;
      x.err = 1'b0;
      x.data = lr2;
      q2.push_back(x);
    end
    @(posedge Clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      chk("b2b_done", 64'(done2), 64'(k % 4 == 3));
      chk("b2b_busy", 64'(busy2), 64'(k % 4 != 0));
      if (k == 9) wr2 = 1'b0;
    end
    access(1, 1, 0, 64'h28, 64'h0);
    access(0, 0, 1, 64'h0, 64'h55);
    access(0, 1, 0, 64'h0, 64'h0);
    access(0, 1, 0, 64'h1C, 64'h0);
    repeat (4) @(negedge Clk);
    chk("drain2", 64'(q2.size()), 64'd0);
    chk("drain0", 64'(q0.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
